// File: rtl/serial_word_sender.sv
// serial_word_sender
//   Feeds the lab universal shift register. It accepts an N-bit word through a
//   valid/ready handshake, then sends it one bit at a time. Each bit comes with
//   a one-cycle strobe (the downstream clock-enable) and a direction flag (the
//   downstream shift_control). A programmable divider stretches each bit to
//   div+1 clk cycles, so the bits can be slowed down enough to watch on LEDs.
//
//   state | meaning
//   IDLE  | waiting for a word; load_ready high
//   SEND  | shifting bits out; strobe when the period counter reaches 0
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   load_valid  producer offers load_data
//   load_ready  word can be accepted (IDLE only)
//   load_data   N-bit word to send
//   msb_first   bit order, sampled on acceptance (1 = bit N-1 first)
//   div         bit period minus 1, sampled on acceptance
//   sd_out      current serial bit
//   sd_strobe   one-cycle pulse; downstream samples sd_out on this edge
//   sd_dir      latched msb_first
//   busy        high in SEND and DONE
//   done        one-cycle pulse after the last strobe
module serial_word_sender #(
  parameter int N     = 4,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N-1:0]     load_data,
  input  logic             msb_first,
  input  logic [DIV_W-1:0] div,
  output logic             sd_out,
  output logic             sd_strobe,
  output logic             sd_dir,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [N-1:0]     word_q;
  logic [IDX_W-1:0] idx_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             dir_q;

  logic [IDX_W-1:0] bit_sel;
  logic             bit_end;

  // The bit period ends on the cycle where the counter has run down to zero.
  assign bit_end = (state_q == SEND) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            word_q  <= load_data;
            dir_q   <= msb_first;
            div_q   <= div;
            cnt_q   <= div;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (cnt_q == '0) begin
            if (idx_q == IDX_LAST) begin
              // idx stays at the last bit so sd_out keeps holding it afterwards.
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              cnt_q <= div_q;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The current bit is selected from the latched word. It stays valid for the
  // whole bit period. It keeps the last bit through DONE and IDLE until the
  // next acceptance clears idx.
  assign bit_sel    = dir_q ? (IDX_LAST - idx_q) : idx_q;
  assign sd_out     = word_q[bit_sel];
  assign sd_strobe  = bit_end;
  assign sd_dir     = dir_q;
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_serial_word_sender.sv
module tb_serial_word_sender;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_valid = 1'b0;
  logic [N-1:0]  load_data = '0;
  logic          msb_first = 1'b0;
  logic [DW-1:0] div = '0;
  logic          load_ready, sd_out, sd_strobe, sd_dir, busy, done;

  serial_word_sender #(.N(N), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .msb_first  (msb_first),
    .div        (div),
    .sd_out     (sd_out),
    .sd_strobe  (sd_strobe),
    .sd_dir     (sd_dir),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Cycle numbering: the value of cyc between two rising edges. A word taken
  // in cycle E strobes bit k in cycle E+(k+1)(div+1).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int b;
  } exp_t;

  exp_t         sbq[$];
  exp_t         e;
  int           free_at = 0;
  int           done_at = -1;
  int           acc_cnt = 0;
  int           str_cnt = 0;
  int           exp_dir = 0;
  int           per;
  logic         mr;
  logic [N-1:0] exp_word = '0;
  logic [N-1:0] ds = '0;
  logic [N-1:0] w_tmp;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_load_ready", load_ready, 1);
      chk("rst_strobe", sd_strobe, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sd_out", sd_out, 0);
      chk("rst_sd_dir", sd_dir, 0);
      sbq.delete();
      free_at = 0;
      done_at = -1;
      ds      = '0;
    end else begin
      mr = (cyc >= free_at);
      chk("load_ready", load_ready, int'(mr));
      chk("busy", busy, int'(!mr));

      if (sbq.size() == 0) begin
        if (sd_strobe) chk("strobe_spurious", 1, 0);
      end else if (sd_strobe || sbq[0].c == cyc) begin
        e = sbq.pop_front();
        chk("strobe_present", sd_strobe, 1);
        chk("strobe_cycle", cyc, e.c);
        chk("sd_out", sd_out, e.b);
        chk("sd_dir", sd_dir, exp_dir);
        str_cnt++;
        // Downstream register: shift-left with d_in at the LSB for msb-first,
        // shift-right with d_in at the MSB otherwise.
        if (sd_dir) ds = {ds[N-2:0], sd_out};
        else        ds = {sd_out, ds[N-1:1]};
      end

      if (done || cyc == done_at) begin
        chk("done", done, int'(cyc == done_at));
        if (cyc == done_at) begin
          chk("ds_word", ds, exp_word);
          chk("dir_hold", sd_dir, exp_dir);
        end
      end

      if (load_valid && mr) begin
        per   = int'(div) + 1;
        w_tmp = load_data;
        for (int k = 0; k < N; k++)
          sbq.push_back('{c: cyc + (k + 1) * per,
                          b: msb_first ? int'(w_tmp[N-1-k]) : int'(w_tmp[k])});
        done_at  = cyc + N * per + 1;
        free_at  = cyc + N * per + 2;
        exp_word = load_data;
        exp_dir  = msb_first;
        str_cnt  = 0;
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [N-1:0] w, input logic m, input int d, input bit hold);
    int a0;
    int n;
    a0 = acc_cnt;
    n  = 0;
    load_data  = w;
    msb_first  = m;
    div        = DW'(d);
    load_valid = 1'b1;
    while (acc_cnt == a0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_cnt == a0) chk("accept_timeout", 0, 1);
    if (!hold) load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(cyc >= free_at && sbq.size() == 0 && done_at < cyc) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    // Reset held with a word offered: nothing may be accepted.
    rst        = 1'b0;
    load_valid = 1'b1;
    load_data  = 4'b1011;
    msb_first  = 1'b1;
    div        = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;

    send(4'b1011, 1'b1, 0, 1'b0);
    wait_idle();

    send(4'b0110, 1'b0, 2, 1'b0);
    wait_idle();

    // Back-to-back with load_valid held high throughout.
    send(4'hA, 1'b1, 1, 1'b1);
    send(4'h5, 1'b0, 1, 1'b0);
    wait_idle();

    // Settings change mid-word must not disturb the word in flight.
    send(4'b1001, 1'b1, 1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    div       = DW'(7);
    msb_first = 1'b0;
    load_data = 4'b0011;
    wait_idle();
    send(4'b0011, 1'b0, 7, 1'b0);
    wait_idle();

    // Reset after the second strobe abandons the word.
    send(4'b1100, 1'b1, 1, 1'b0);
    n = 0;
    while (str_cnt < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (str_cnt < 2) chk("strobe_wait_timeout", 0, 1);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    send(4'b1111, 1'b1, 0, 1'b0);
    wait_idle();
    repeat (3) begin
      @(posedge clk); #1;
    end

    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
